// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;
    localparam int unsigned MEM_SIZE = 1024;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D
    } resp_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data first, fetch wins once starved.
module mem_arb_pick
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        if_req,
    input  logic        d_req,
    input  logic [3:0]  streak,
    output logic        if_gnt,
    output logic        d_gnt,
    output resp_owner_t owner
);

    logic starve;

    assign starve = if_req && (streak == 4'(STARVE_LIMIT));
    assign if_gnt = if_req && (!d_req || starve);
    assign d_gnt  = d_req && !if_gnt;

    always_comb begin
        owner = RESP_NONE;
        unique case (1'b1)
            if_gnt:  owner = RESP_IF;
            d_gnt:   owner = RESP_D;
            default: owner = RESP_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port synchronous memory.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = mem_pkg::MEM_SIZE,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [BE_W-1:0] d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic            mem_en,
    output logic [BE_W-1:0] mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    logic            if_live;
    logic            d_live;
    logic [3:0]      streak;
    resp_owner_t     owner;
    resp_owner_t     resp;
    logic            err_q;
    logic            st_q;
    logic            any_gnt;
    logic            store;
    logic            legal;
    logic [XLEN-1:0] addr;

    // Requests are masked while reset is held so every output reads 0.
    assign if_live = if_req && rst_n;
    assign d_live  = d_req && rst_n;

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .if_req (if_live),
        .d_req  (d_live),
        .streak (streak),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt),
        .owner  (owner)
    );

    assign any_gnt = if_gnt || d_gnt;
    assign store   = d_gnt && d_we;
    assign addr    = if_gnt ? if_addr : d_addr;
    assign legal   = (addr < XLEN'(MEM_SIZE)) && (addr[1:0] == 2'b00);

    assign mem_en    = any_gnt && legal;
    assign mem_addr  = mem_en ? addr : '0;
    assign mem_we    = (mem_en && store) ? d_be : '0;
    assign mem_wdata = (mem_en && store) ? d_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
            resp   <= RESP_NONE;
            err_q  <= 1'b0;
            st_q   <= 1'b0;
        end else begin
            if (!if_live || if_gnt) begin
                streak <= '0;
            end else if (d_gnt) begin
                streak <= streak + 4'd1;
            end
            resp  <= owner;
            err_q <= any_gnt && !legal;
            st_q  <= store;
        end
    end

    assign if_rvalid = (resp == RESP_IF);
    assign if_err    = if_rvalid && err_q;
    assign if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;

    assign d_rvalid = (resp == RESP_D);
    assign d_err    = d_rvalid && err_q;
    assign d_rdata  = (d_rvalid && !err_q && !st_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 32-byte behavioural memory.
module tb_mem_arbiter;

    localparam int MSZ = 32;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h5A5A_5A5A;

    logic [7:0]  mem  [MSZ];
    logic [7:0]  gold [MSZ];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_SIZE(MSZ), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= {mem[mem_addr[4:0] + 5'd3], mem[mem_addr[4:0] + 5'd2],
                          mem[mem_addr[4:0] + 5'd1], mem[mem_addr[4:0]]};
            for (int b = 0; b < 4; b++)
                if (mem_we[b])
                    mem[mem_addr[4:0] + 5'(b)] <= mem_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] gword(int a);
        return {gold[a+3], gold[a+2], gold[a+1], gold[a]};
    endfunction

    function automatic void push(bit is_d, bit err, logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Response monitor: every accepted request must answer one cycle later.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_d) begin
                if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_err !== e.err ||
                    d_rdata !== e.data || if_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL d_resp: rvalid=%b err=%b rdata=%h if_rdata=%h want err=%b rdata=%h",
                             d_rvalid, d_err, d_rdata, if_rdata, e.err, e.data);
                end
            end else begin
                if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_err !== e.err ||
                    if_rdata !== e.data || d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL if_resp: rvalid=%b err=%b rdata=%h d_rdata=%h want err=%b rdata=%h",
                             if_rvalid, if_err, if_rdata, d_rdata, e.err, e.data);
                end
            end
        end else if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_resp: if_rvalid=%b d_rvalid=%b want 0 0",
                     if_rvalid, d_rvalid);
        end
    end

    task automatic idle();
        if_req = 0; d_req = 0; d_we = 0; d_be = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        logic [211:0] outs;
        rst_n = 0;
        idle();
        if_req = 1; if_addr = 4;
        d_req = 1; d_addr = 0;
        repeat (2) begin
            @(negedge clk);
            outs = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata,
                    d_err, mem_en, mem_we, mem_addr, mem_wdata};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outs: got %h want 0", outs);
            end
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1 || if_gnt !== 0 || d_rvalid !== 0 || if_rvalid !== 0) begin
            errors++;
            $display("FAIL reset_first_gnt: d_gnt=%b if_gnt=%b rvalid=%b%b want 1 0 00",
                     d_gnt, if_gnt, d_rvalid, if_rvalid);
        end
        @(posedge clk);
        push(1, 0, gword(0));
        #1 idle();
    endtask

    task automatic test_fetch_sweep();
        for (int a = 0; a < MSZ; a += 4) begin
            if_req = 1; if_addr = a;
            @(negedge clk);
            checks++;
            if (if_gnt !== 1 || d_gnt !== 0 || mem_en !== 1 ||
                mem_addr !== 32'(a) || mem_we !== 4'h0) begin
                errors++;
                $display("FAIL fetch_gnt@%0d: gnt=%b en=%b addr=%h we=%h want 1 1 %h 0",
                         a, if_gnt, mem_en, mem_addr, mem_we, a);
            end
            @(posedge clk);
            push(0, 0, gword(a));
            #1;
        end
        idle();
    endtask

    task automatic test_store_load();
        d_req = 1; d_we = 1; d_be = 4'b0101; d_addr = 8; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1 || mem_en !== 1 || mem_we !== 4'b0101 ||
            mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'd8) begin
            errors++;
            $display("FAIL store_issue: gnt=%b en=%b we=%b wdata=%h addr=%h want 1 1 0101 deadbeef 8",
                     d_gnt, mem_en, mem_we, mem_wdata, mem_addr);
        end
        @(posedge clk);
        push(1, 0, 32'h0);
        gold[8]  = 8'hEF;
        gold[10] = 8'hAD;
        #1;
        d_we = 0; d_be = 0; d_wdata = 0;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1 || mem_en !== 1 || mem_we !== 4'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL load_issue: gnt=%b en=%b we=%b wdata=%h want 1 1 0 0",
                     d_gnt, mem_en, mem_we, mem_wdata);
        end
        @(posedge clk);
        push(1, 0, {gold[11], 8'hAD, gold[9], 8'hEF});
        #1 idle();
    endtask

    task automatic test_contention();
        bit want_if;
        @(posedge clk); #1;
        if_req = 1; if_addr = 20;
        d_req = 1; d_addr = 16;
        for (int i = 0; i < 15; i++) begin
            want_if = (i % 5 == 4);
            @(negedge clk);
            checks++;
            if (if_gnt !== want_if || d_gnt !== !want_if) begin
                errors++;
                $display("FAIL contention[%0d]: if_gnt=%b d_gnt=%b want %b %b",
                         i, if_gnt, d_gnt, want_if, !want_if);
            end
            @(posedge clk);
            if (want_if) push(0, 0, gword(20));
            else push(1, 0, gword(16));
            #1;
        end
        idle();
    endtask

    task automatic test_errors();
        d_req = 1; d_addr = 32;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1 || mem_en !== 0) begin
            errors++;
            $display("FAIL err_range_issue: gnt=%b en=%b want 1 0", d_gnt, mem_en);
        end
        @(posedge clk);
        push(1, 1, 32'h0);
        #1 idle();
        if_req = 1; if_addr = 6;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1 || mem_en !== 0) begin
            errors++;
            $display("FAIL err_align_issue: gnt=%b en=%b want 1 0", if_gnt, mem_en);
        end
        @(posedge clk);
        push(0, 1, 32'h0);
        #1 idle();
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 34; d_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1 || mem_en !== 0 || mem_we !== 4'h0) begin
            errors++;
            $display("FAIL err_store_issue: gnt=%b en=%b we=%h want 1 0 0",
                     d_gnt, mem_en, mem_we);
        end
        @(posedge clk);
        push(1, 1, 32'h0);
        #1 idle();
        @(negedge clk);
        for (int i = 0; i < MSZ; i++) begin
            checks++;
            if (mem[i] !== gold[i]) begin
                errors++;
                $display("FAIL mem_intact[%0d]: got %h want %h", i, mem[i], gold[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_addr = 12;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1) begin
            errors++;
            $display("FAIL mid_gnt: got %b want 1", d_gnt);
        end
        #1 rst_n = 0;
        idle();
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (d_rvalid !== 0) begin
                errors++;
                $display("FAIL mid_in_reset: d_rvalid=%b want 0", d_rvalid);
            end
        end
        rst_n = 1;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (d_rvalid !== 0 || if_rvalid !== 0) begin
                errors++;
                $display("FAIL mid_after_release: rvalid=%b%b want 00", d_rvalid, if_rvalid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MSZ; i++) begin
            mem[i]  = 8'(i * 7 + 1);
            gold[i] = 8'(i * 7 + 1);
        end
        test_reset();
        test_fetch_sweep();
        test_store_load();
        test_contention();
        test_errors();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_resp: got %0d outstanding want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
